// File: rtl/fifo_rd_stream.sv
// Turns a synchronous FIFO read port (1-cycle read latency) into a valid/ready
// stream through a 2-entry skid buffer, so reads can be issued ahead of demand.
module fifo_rd_stream #(
  parameter int G_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fifo_empty,
  input  logic [G_WIDTH-1:0] i_fifo_data,
  output logic               o_fifo_rd,
  output logic               o_valid,
  output logic [G_WIDTH-1:0] o_data,
  input  logic               i_ready,
  output logic [1:0]         o_occ,
  output logic [15:0]        o_beats
);

  // state   | meaning
  // S_EMPTY | no buffered word, o_valid low
  // S_ONE   | head word in r_buf0
  // S_TWO   | head in r_buf0, next word in r_buf1
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } t_occ;

  t_occ               r_occ;
  t_occ               w_occ_nxt;
  logic               r_inflight;
  logic [G_WIDTH-1:0] r_buf0;
  logic [G_WIDTH-1:0] r_buf1;
  logic [G_WIDTH-1:0] w_buf0_nxt;
  logic [G_WIDTH-1:0] w_buf1_nxt;
  logic [15:0]        r_beats;
  logic               w_pop;
  logic               w_cap;
  logic [2:0]         w_level;

  assign o_valid = (r_occ != S_EMPTY);
  assign o_data  = r_buf0;
  assign o_occ   = r_occ;
  assign o_beats = r_beats;

  assign w_pop = o_valid & i_ready;
  assign w_cap = r_inflight;

  // Words already owed to the buffer after this cycle's pop; a new read is
  // only safe if it still fits in two entries when it lands.
  assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign o_fifo_rd = i_rst_n & ~i_fifo_empty & (w_level < 3'd2);

  always_comb begin
    w_occ_nxt  = r_occ;
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    case (r_occ)
      S_EMPTY: begin
        if (w_cap) begin
          w_occ_nxt  = S_ONE;
          w_buf0_nxt = i_fifo_data;
        end
      end
      S_ONE: begin
        if (w_cap && w_pop) begin
          w_buf0_nxt = i_fifo_data;
        end else if (w_cap) begin
          w_occ_nxt  = S_TWO;
          w_buf1_nxt = i_fifo_data;
        end else if (w_pop) begin
          w_occ_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        // Capture without pop cannot occur here: the read gate above forbids it.
        if (w_pop) begin
          w_buf0_nxt = r_buf1;
          if (w_cap) begin
            w_buf1_nxt = i_fifo_data;
          end else begin
            w_occ_nxt = S_ONE;
          end
        end
      end
      default: begin
        w_occ_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_occ      <= S_EMPTY;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_beats    <= 16'd0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= o_fifo_rd;
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
      if (w_pop) begin
        r_beats <= r_beats + 16'd1;
      end
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter G_WIDTH, default 8: data width in bits of the FIFO read port and the output stream.
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1  reset; synchronous, active-low.
REQ-004 i_fifo_empty  in  1  empty flag from the upstream synchronous FIFO.
REQ-005 i_fifo_data  in  G_WIDTH  FIFO read data, valid one cycle after an accepted read strobe.
REQ-006 o_fifo_rd  out  1  read strobe to the FIFO.
REQ-007 o_valid  out  1  output stream beat valid.
REQ-008 o_data  out  G_WIDTH  output stream data.
REQ-009 i_ready  in  1  downstream ready; a beat transfers when o_valid and i_ready are both high in the same cycle.
REQ-010 o_occ  out  2  current skid-buffer occupancy, 0..2.
REQ-011 o_beats  out  16  count of transferred output beats.

Function
REQ-012 The block SHALL convert the FIFO read interface into a valid/ready stream and SHALL preserve FIFO order exactly.
REQ-013 The block SHALL hold a 2-entry skid buffer with occupancy states EMPTY(0), ONE(1) and TWO(2), plus an in-flight bit set for one cycle after each issued read.
REQ-014 o_fifo_rd SHALL be combinational: asserted iff i_rst_n=1, i_fifo_empty=0 and (occ + inflight - pop) < 2, where pop = o_valid and i_ready.
REQ-015 Read latency: i_fifo_data present in the cycle after o_fifo_rd=1 SHALL be captured into the buffer at that cycle's rising edge.
REQ-016 Occupancy transitions: capture only -> occ+1; pop only -> occ-1; capture and pop together -> occ unchanged, with the head advancing and the new word appended at the tail.
REQ-017 Occupancy SHALL never exceed 2. No word SHALL be dropped or duplicated.
REQ-018 o_valid SHALL equal (occ != 0). o_data SHALL equal the head entry and SHALL be stable while o_valid=1 and i_ready=0.
REQ-019 The block SHALL sustain one beat per cycle when the FIFO stays non-empty and i_ready stays 1, after an initial 2-cycle latency from the first read.
REQ-020 o_beats SHALL increment by 1 on each transfer and wrap from 16'hFFFF to 0.
REQ-021 With i_fifo_empty=1, no read SHALL be issued. Buffered beats SHALL still drain to the output.
REQ-022 The block SHALL tolerate i_ready toggling at any time: with occ=2 and i_ready=0, o_fifo_rd SHALL stay 0.

Reset
REQ-023 While i_rst_n=0 at a rising edge, the block SHALL clear occ, inflight, the buffer contents and o_beats to 0.
REQ-024 While i_rst_n=0, o_fifo_rd SHALL be 0.
REQ-025 After reset: o_valid=0, o_data=0, o_occ=0, o_beats=0.
REQ-026 Reset asserted mid-operation SHALL discard buffered and in-flight words. A FIFO word returning in the cycle after reset SHALL NOT be captured.

Verification
REQ-027 Reset, then FIFO holds A1,A2,A3 with i_ready=1 -> o_fifo_rd high in cycles 0-2. o_valid with A1,A2,A3 in cycles 2-4. o_beats=3.
REQ-028 FIFO non-empty, i_ready=0 -> exactly 2 reads issued. Occupancy settles at 2 and o_fifo_rd stays 0. o_data holds the first word.
REQ-029 Occupancy 2, then i_ready=1 continuously with the FIFO non-empty -> one beat per cycle with no gaps, in order. o_occ never exceeds 2.
REQ-030 i_ready toggles 1,0,1,0 over 8 words -> all 8 delivered in order with no duplicates, and o_beats=8.
REQ-031 Reset pulsed one cycle after a read issue, with occ=1 -> o_valid=0 and o_occ=0 after reset. The returning word is not output.
REQ-032 Preload o_beats to 16'hFFFE via stimulus, then 3 transfers -> o_beats reads FFFF, 0000, 0001.
